mac_acc_seq: RTL and testbench

Job sequencer for the MAC accumulator datapath. It accepts a job command (initial value and beat count) and streams that many operand beats through an internal W-bit running sum with carry. It then presents the final sum, plus a sticky overflow flag, on a valid/ready result port. It sits between the multiplier/operand stream and the result writeback, and owns all sequencing of the accumulate register (load-init, add, hold).

---
 rtl/mac_acc_seq_if.sv | 33 +++
 rtl/mac_acc_seq.sv | 111 +++++++++++
 tb/tb_mac_acc_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mac_acc_seq_if.sv
// Job/operand/result handshake bundle for the MAC accumulator sequencer.
//   cmd_*  : job command (initial value, beat count), valid/ready
//   in_*   : operand beat stream, valid/ready
//   out_*  : final sum and sticky overflow, valid/ready
// master = job/operand producer and result consumer; slave = sequencer.
interface mac_acc_seq_if #(
  parameter int unsigned W         = 32,
  parameter int unsigned LEN_WIDTH = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [W-1:0]         cmd_init;
  logic [LEN_WIDTH-1:0] cmd_len;

  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_data;
  logic                 out_ovf;

  modport master (
    output cmd_valid, cmd_init, cmd_len, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  cmd_valid, cmd_init, cmd_len, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mac_acc_seq.sv
// Job sequencer for the MAC accumulator: loads an initial value, adds
// cmd_len unsigned operand beats with carry tracking, then offers the
// wrapped sum and a sticky overflow flag on the result port.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset (abandons any job in flight)
//   bus   : mac_acc_seq_if.slave (cmd / in / out handshakes)
//   busy  : high while a job is in ACC or OUT
module mac_acc_seq #(
  parameter int unsigned MAC_MIN_WIDTH = 8,
  parameter int unsigned MAC_ACC_WIDTH = 4 * MAC_MIN_WIDTH,
  parameter int unsigned LEN_WIDTH     = 8
) (
  input  logic               clk,
  input  logic               rst,
  mac_acc_seq_if.slave       bus,
  output logic               busy
);
  localparam int unsigned W = MAC_ACC_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t               state;
  logic [W-1:0]         sum;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 ovf;
  logic                 cmd_ready_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  // W+1-bit add; the top bit is the carry out of bit W-1.
  logic [W:0] sum_ext_c;
  assign sum_ext_c = {1'b0, sum} + {1'b0, bus.in_data};

  // Sequencer: state, datapath and handshake outputs all registered together,
  // so each ready/valid always matches the state it is decoded from.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sum         <= '0;
      remaining   <= '0;
      ovf         <= 1'b0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            sum         <= bus.cmd_init;
            remaining   <= bus.cmd_len;
            ovf         <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.cmd_len == '0) begin
              state       <= OUT;
              out_valid_q <= 1'b1;
            end else begin
              state      <= ACC;
              in_ready_q <= 1'b1;
            end
          end
        end

        ACC: begin
          if (bus.in_valid) begin
            sum       <= sum_ext_c[W-1:0];
            ovf       <= ovf | sum_ext_c[W];
            remaining <= remaining - LEN_WIDTH'(1);
            // Leave on the last beat, so remaining never wraps below zero.
            if (remaining == LEN_WIDTH'(1)) begin
              state       <= OUT;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end

        OUT: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b1;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = sum;
  assign bus.out_ovf   = ovf;
  assign busy          = busy_q;
endmodule

// File: tb/tb_mac_acc_seq.sv
// Directed self-checking bench for mac_acc_seq. Inputs change and outputs
// are sampled on the falling edge; the design acts on the rising edge.
module tb_mac_acc_seq;
  localparam int unsigned W  = 32;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int checks   = 0;
  int failures = 0;

  mac_acc_seq_if #(.W(W), .LEN_WIDTH(LW)) bus ();

  mac_acc_seq #(.MAC_MIN_WIDTH(8), .MAC_ACC_WIDTH(W), .LEN_WIDTH(LW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Runs one job up to the first cycle with out_valid; out_ready stays low.
  // Beat i carries base + i*step; in_valid follows pat (LSB first) for the
  // first pat_len ACC cycles and is held high afterwards.
  // lat counts cycles from the command accept edge: 1 = cycle right after.
  task automatic run_job(input logic [W-1:0] init, input int len,
                         input logic [W-1:0] base, input logic [W-1:0] step,
                         input logic [31:0] pat, input int pat_len,
                         output int lat, output bit saw_in_ready);
    int beat_i = 0;
    int pat_i  = 0;
    logic v;
    saw_in_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_init  = init;
    bus.cmd_len   = LW'(len);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 1000) begin
      if (bus.in_ready) begin
        saw_in_ready = 1'b1;
        v = (pat_i < pat_len) ? pat[pat_i] : 1'b1;
        pat_i++;
      end else begin
        v = 1'b0;
      end
      bus.in_valid = v;
      bus.in_data  = base + W'(beat_i) * step;
      if (v && bus.in_ready) beat_i++;
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    if (lat >= 1000) check("job_timeout", 64'(lat), 64'(0));
  endtask

  // Accept the pending result and confirm the return to IDLE.
  task automatic take(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle_cmd_ready"}, 64'(bus.cmd_ready), 64'(1));
    check({tag, "_idle_out_valid"}, 64'(bus.out_valid), 64'(0));
  endtask

  int lat;
  bit saw;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_init = '0; bus.cmd_len = '0;
    bus.in_valid  = 1'b0; bus.in_data  = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("rst_in_ready",  64'(bus.in_ready),  64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data",  64'(bus.out_data),  64'(0));
    check("rst_out_ovf",   64'(bus.out_ovf),   64'(0));
    check("rst_busy",      64'(busy),          64'(0));

    // Basic: 10 + 1 + 2 + 3
    run_job(32'd10, 3, 32'd1, 32'd1, 32'hFFFF_FFFF, 0, lat, saw);
    check("basic_data", 64'(bus.out_data), 64'(16));
    check("basic_ovf",  64'(bus.out_ovf),  64'(0));
    check("basic_lat",  64'(lat),          64'(4));
    check("basic_busy", 64'(busy),         64'(1));
    take("basic");

    // Overflow: first add carries, second does not; flag stays set.
    run_job(32'hFFFF_FFFF, 2, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, lat, saw);
    check("ovf_data", 64'(bus.out_data), 64'(1));
    check("ovf_ovf",  64'(bus.out_ovf),  64'(1));
    check("ovf_lat",  64'(lat),          64'(3));
    take("ovf");

    // Zero length: result the cycle after accept, no operand phase.
    run_job(32'h1234, 0, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, lat, saw);
    check("zero_data",     64'(bus.out_data), 64'h1234);
    check("zero_ovf",      64'(bus.out_ovf),  64'(0));
    check("zero_lat",      64'(lat),          64'(1));
    check("zero_in_ready", 64'(saw),          64'(0));
    take("zero");

    // Gaps: in_valid 1,0,0,1,1,0,1 -> beats on ACC cycles 1,4,5,7.
    run_job(32'd100, 4, 32'd5, 32'd0, 32'b1011001, 7, lat, saw);
    check("gap_data", 64'(bus.out_data), 64'(120));
    check("gap_ovf",  64'(bus.out_ovf),  64'(0));
    check("gap_lat",  64'(lat),          64'(8));
    // Back-pressure with stray cmd/in traffic that must be ignored.
    bus.cmd_valid = 1'b1; bus.cmd_len = 8'd1; bus.cmd_init = 32'hDEAD;
    bus.in_valid  = 1'b1; bus.in_data = 32'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data",      64'(bus.out_data),  64'(120));
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_cmd_ready", 64'(bus.cmd_ready), 64'(0));
      check("bp_in_ready",  64'(bus.in_ready),  64'(0));
    end
    bus.cmd_valid = 1'b0; bus.in_valid = 1'b0;
    take("bp");

    // Reset mid-job after two beats.
    bus.cmd_valid = 1'b1; bus.cmd_init = 32'd7; bus.cmd_len = 8'd5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b1; bus.in_data = 32'd3;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("mrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mrst_out_data",  64'(bus.out_data),  64'(0));
    check("mrst_in_ready",  64'(bus.in_ready),  64'(0));
    check("mrst_busy",      64'(busy),          64'(0));
    run_job(32'd0, 1, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, lat, saw);
    check("post_rst_data", 64'(bus.out_data), 64'(9));
    check("post_rst_ovf",  64'(bus.out_ovf),  64'(0));
    check("post_rst_lat",  64'(lat),          64'(2));
    take("post_rst");

    // Maximum length: 255 beats of 0x01000000.
    run_job(32'd0, 255, 32'h0100_0000, 32'd0, 32'hFFFF_FFFF, 0, lat, saw);
    check("max_data", 64'(bus.out_data), 64'hFF00_0000);
    check("max_ovf",  64'(bus.out_ovf),  64'(0));
    check("max_lat",  64'(lat),          64'(256));
    take("max");
    run_job(32'h0100_0000, 255, 32'h0100_0000, 32'd0, 32'hFFFF_FFFF, 0, lat, saw);
    check("maxwrap_data", 64'(bus.out_data), 64'(0));
    check("maxwrap_ovf",  64'(bus.out_ovf),  64'(1));
    take("maxwrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
